// File: rtl/parity_tx_sequencer.sv
// Round-robin two-requester serial frame transmitter with odd parity (start/8 data LSB-first/parity/stop).
// Optional parity slot on the line is enabled by defining TX_PARITY_EN; without it the frame is 10 bits.
module parity_tx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       CLK100MHZ,
  input  logic       resetSW_n,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_b,
  output logic       parity_bit,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             grant_b_q, grant_b_d;
  logic             last_b_q, last_b_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic [7:0]       sel_data;

  // Round-robin grant; ready is combinational and only offered in IDLE outside reset
  always_comb begin
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    if (resetSW_n && (state_q == S_IDLE)) begin
      req_a_ready = req_a_valid && (!req_b_valid || last_b_q);
      req_b_ready = req_b_valid && (!req_a_valid || !last_b_q);
    end
  end

  assign bit_end  = (cnt_q == CNT_LAST);
  assign sel_data = req_b_ready ? req_b_data : req_a_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    tx_d      = 1'b1;
    busy_d    = (state_q != S_IDLE);
    // Pulse one cycle after the state machine has returned to IDLE
    done_d    = (state_q == S_IDLE) && busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (req_a_ready || req_b_ready) begin
          shift_d   = sel_data;
          parity_d  = ~^sel_data;
          grant_b_d = req_b_ready;
          last_b_d  = req_b_ready;
          cnt_d     = '0;
          idx_d     = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_d  = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d  = shift_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        tx_d  = parity_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetSW_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      grant_b_q <= grant_b_d;
      last_b_q  <= last_b_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_b    = grant_b_q;
  assign parity_bit = parity_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_tx_sequencer.sv
// Directed bench for parity_tx_sequencer at CLKS_PER_BIT=4; frame length follows TX_PARITY_EN.
module tb_parity_tx_sequencer;

  localparam int unsigned CPB = 4;
`ifdef TX_PARITY_EN
  localparam int unsigned NBITS  = 11;
  localparam bit          PAR_EN = 1'b1;
`else
  localparam int unsigned NBITS  = 10;
  localparam bit          PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic       tx, busy, grant_b, parity_bit, frame_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_tx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .CLK100MHZ  (clk),
    .resetSW_n  (rst_n),
    .req_a_valid(a_valid),
    .req_a_data (a_data),
    .req_a_ready(a_ready),
    .req_b_valid(b_valid),
    .req_b_data (b_data),
    .req_b_ready(b_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_b    (grant_b),
    .parity_bit (parity_bit),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    #1;
    while (!(a_ready || b_ready) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Runs one frame from the cycle before the accept edge through the last stop-bit cycle
  task automatic frame(input string tag, input logic exp_b, input logic [7:0] d,
                       input logic exp_p, input logic chain);
    logic [10:0] bits;
    logic [7:0]  sa, sb;
    if (!chain) wait_ready();
    check({tag, ".rdy_a"}, 32'(a_ready), 32'(!exp_b));
    check({tag, ".rdy_b"}, 32'(b_ready), 32'(exp_b));
    @(negedge clk);
    check({tag, ".grant_b"}, 32'(grant_b), 32'(exp_b));
    check({tag, ".parity"}, 32'(parity_bit), 32'(exp_p));
    check({tag, ".done0"}, 32'(frame_done), 32'(chain));
    check({tag, ".tx0"}, 32'(tx), 32'd1);
    check({tag, ".busy0"}, 32'(busy), 32'd0);
    sa = a_data;
    sb = b_data;
    a_data = ~sa;
    b_data = ~sb;
    bits = PAR_EN ? {1'b1, exp_p, d, 1'b0} : {1'b1, 1'b1, d, 1'b0};
    for (int k = 1; k <= int'(NBITS * CPB); k++) begin
      @(negedge clk);
      check($sformatf("%s.tx%0d", tag, k), 32'(tx), 32'(bits[(k - 1) / CPB]));
      check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
    end
    a_data = sa;
    b_data = sb;
  endtask

  task automatic finish_single(input string tag);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, 32'(frame_done), 32'd1);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".tx_end"}, 32'(tx), 32'd1);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.tx", 32'(tx), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(frame_done), 32'd0);
    check("rst.grant_b", 32'(grant_b), 32'd0);
    check("rst.parity", 32'(parity_bit), 32'd0);
    check("rst.rdy", 32'({a_ready, b_ready}), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = 8'h00;
    b_data  = 8'h00;
    do_reset();

    // A sends 0x55 once
    a_data  = 8'h55;
    a_valid = 1'b1;
    frame("a55", 1'b0, 8'h55, 1'b1, 1'b0);
    finish_single("a55");

    // Parity slot values: 0x00 then 0x01 back to back
    a_data  = 8'h00;
    a_valid = 1'b1;
    frame("a00", 1'b0, 8'h00, 1'b1, 1'b0);
    a_data = 8'h01;
    frame("a01", 1'b0, 8'h01, 1'b0, 1'b1);
    finish_single("a01");

    // Both held valid from reset: A, B, A, B
    do_reset();
    a_data  = 8'hA5;
    b_data  = 8'h3C;
    a_valid = 1'b1;
    b_valid = 1'b1;
    frame("rr0", 1'b0, 8'hA5, 1'b1, 1'b0);
    frame("rr1", 1'b1, 8'h3C, 1'b1, 1'b1);
    frame("rr2", 1'b0, 8'hA5, 1'b1, 1'b1);
    frame("rr3", 1'b1, 8'h3C, 1'b1, 1'b1);
    finish_single("rr3");

    // Only B valid for three frames
    b_data  = 8'h07;
    b_valid = 1'b1;
    frame("b0", 1'b1, 8'h07, 1'b0, 1'b0);
    frame("b1", 1'b1, 8'h07, 1'b0, 1'b1);
    frame("b2", 1'b1, 8'h07, 1'b0, 1'b1);
    finish_single("b2");

    // Reset during DATA bit 3, then both pending: A must win after reset
    a_data  = 8'h55;
    a_valid = 1'b1;
    wait_ready();
    check("ab.rdy_a", 32'(a_ready), 32'd1);
    @(negedge clk);
    repeat (17) @(negedge clk);
    rst_n   = 1'b0;
    b_data  = 8'h3C;
    b_valid = 1'b1;
    @(negedge clk);
    check("ab.tx", 32'(tx), 32'd1);
    check("ab.busy", 32'(busy), 32'd0);
    check("ab.done", 32'(frame_done), 32'd0);
    check("ab.grant_b", 32'(grant_b), 32'd0);
    check("ab.rdy", 32'({a_ready, b_ready}), 32'd0);
    rst_n = 1'b1;
    frame("ab_a", 1'b0, 8'h55, 1'b1, 1'b0);
    finish_single("ab_a");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
